button_conditioner: RTL and testbench

- Upstream stage of the LED counter. Turns the raw, bouncing, active-low push button into clean, synchronous, active-high events.
- Outputs are a debounced level, a one-cycle press pulse, auto-repeat pulses while the button is held, and a release pulse.
- The downstream counter and display-timer logic consume `step` and `pressed` directly in the clk_50mhz domain, so that logic needs no divided clock.

---
 rtl/blinky_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_conditioner.sv | 146 ++++++++++++++
 tb/tb_button_conditioner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// Shared types and 50 MHz timing defaults for the push-button / LED counter slice.
package blinky_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_50M = 1_000_000;   // 20 ms
  localparam int unsigned HOLD_CYCLES_50M     = 25_000_000;  // 0.5 s
  localparam int unsigned REPEAT_CYCLES_50M   = 5_000_000;   // 0.1 s
  localparam int unsigned BTN_CNT_W           = 25;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; reset value is a parameter
// so idle-high inputs (active-low buttons) do not fake an event out of reset.
module sync_2ff #(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces the raw active-low button into pressed level, press/repeat/release pulses and step.
// Define BUTTON_COND_ACCEL_EN to make auto-repeat speed up while the button stays held.
module button_conditioner
  import blinky_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_50M,
  parameter int unsigned CNT_W           = BTN_CNT_W
) (
  input  logic clk_50mhz,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic step
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             button_sync;
  logic             btn_s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] timer_q;
  logic             rep_last;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk_50mhz),
    .rst (reset),
    .d   (button),
    .q   (button_sync)
  );

  assign btn_s = ~button_sync;

`ifdef BUTTON_COND_ACCEL_EN
  // Period halves every 8 repeats, never dropping below an eighth of the base period.
  localparam logic [CNT_W-1:0] PER_BASE  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] PER_FLOOR = (REPEAT_CYCLES / 8 > 0) ? CNT_W'(REPEAT_CYCLES / 8)
                                                                   : CNT_W'(1);
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_half;
  logic [CNT_W-1:0] per_next;
  logic [2:0]       rep_cnt_q;

  assign per_half = per_q >> 1;
  assign per_next = (per_half < PER_FLOOR) ? PER_FLOOR : per_half;
  assign rep_last = (timer_q == per_q - CNT_W'(1));
`else
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  assign rep_last = (timer_q == REP_LAST);
`endif

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
`ifdef BUTTON_COND_ACCEL_EN
      per_q         <= PER_BASE;
      rep_cnt_q     <= '0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
      timer_q       <= timer_q + 1'b1;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (btn_s) state_q <= DB_PRESS;
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == DB_LAST) begin
            state_q     <= HELD;
            timer_q     <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            step        <= 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= DB_RELEASE;
            timer_q <= '0;
          end else if (timer_q == HOLD_LAST) begin
            state_q      <= REPEAT;
            timer_q      <= '0;
            repeat_pulse <= 1'b1;
            step         <= 1'b1;
`ifdef BUTTON_COND_ACCEL_EN
            per_q        <= PER_BASE;
            rep_cnt_q    <= '0;
`endif
          end
        end
        REPEAT: begin
          // Release is checked first so a fall on the terminal count suppresses the repeat.
          if (!btn_s) begin
            state_q <= DB_RELEASE;
            timer_q <= '0;
          end else if (rep_last) begin
            timer_q      <= '0;
            repeat_pulse <= 1'b1;
            step         <= 1'b1;
`ifdef BUTTON_COND_ACCEL_EN
            rep_cnt_q    <= rep_cnt_q + 3'd1;
            if (rep_cnt_q == 3'd7) per_q <= per_next;
`endif
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state_q <= HELD;
            timer_q <= '0;
          end else if (timer_q == DB_LAST) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;
`ifdef BUTTON_COND_ACCEL_EN
  localparam int R = 16;
`else
  localparam int R = 3;
`endif
  localparam int FLOOR = (R / 8 > 0) ? R / 8 : 1;

  logic clk_50mhz = 1'b0;
  logic reset     = 1'b1;
  logic button    = 1'b1;
  logic pressed, press_pulse, repeat_pulse, release_pulse, step;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  // Reference model: synchronizer pipe plus run lengths of the synchronized level.
  bit m_s0, m_s1, m_held, m_rep_mode;
  int m_ones, m_zeros, m_since, m_per, m_cnt;
  logic [4:0] exp_q[$];  // {pressed, press_pulse, repeat_pulse, release_pulse, step}

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .CNT_W           (8)
  ) dut (
    .clk_50mhz     (clk_50mhz),
    .reset         (reset),
    .button        (button),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .repeat_pulse  (repeat_pulse),
    .release_pulse (release_pulse),
    .step          (step)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  task automatic model_reset();
    m_s0 = 1'b1; m_s1 = 1'b1; m_held = 1'b0; m_rep_mode = 1'b0;
    m_ones = 0; m_zeros = 0; m_since = 0; m_per = R; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic b_raw);
    bit bs;
    bit pp, rp, rl;
    pp = 1'b0; rp = 1'b0; rl = 1'b0;
    bs = ~m_s1;
    m_s1 = m_s0;
    m_s0 = b_raw;
    if (!m_held) begin
      m_ones = bs ? m_ones + 1 : 0;
      if (m_ones == D + 1) begin
        m_held = 1'b1; pp = 1'b1; m_ones = 0; m_zeros = 0; m_since = 0; m_rep_mode = 1'b0;
      end
    end else if (!bs) begin
      m_zeros++;
      if (m_zeros == D + 1) begin
        m_held = 1'b0; rl = 1'b1; m_zeros = 0;
      end
    end else if (m_zeros > 0) begin
      m_zeros = 0; m_since = 0; m_rep_mode = 1'b0;
    end else begin
      m_since++;
      if (!m_rep_mode && m_since == H) begin
        rp = 1'b1; m_rep_mode = 1'b1; m_since = 0; m_per = R; m_cnt = 0;
      end else if (m_rep_mode && m_since == m_per) begin
        rp = 1'b1; m_since = 0;
`ifdef BUTTON_COND_ACCEL_EN
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_per = (m_per / 2 > FLOOR) ? m_per / 2 : FLOOR;
        end
`endif
      end
    end
    exp_q.push_back({m_held, pp, rp, rl, pp | rp});
  endtask

  // Called at a negedge; returns at the following negedge with the model advanced one edge.
  task automatic drive(input logic b);
    button = b;
    @(posedge clk_50mhz);
    model_edge(b);
    edge_n++;
    @(negedge clk_50mhz);
  endtask

  task automatic apply_reset();
    @(negedge clk_50mhz);
    reset  = 1'b1;
    button = 1'b1;
    model_reset();
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic [4:0] obs, exp;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      button = 1'b0;
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      vectors++;
      if (obs !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_state i=%0d got=%b exp=00000", i, obs);
      end
    end
    button = 1'b1;
    reset  = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_idle edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] obs, exp;
    int first_press, rep_edges[$];
    first_press = -1;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clean_press edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (press_pulse === 1'b1 && first_press < 0) first_press = edge_n;
      if (repeat_pulse === 1'b1) rep_edges.push_back(edge_n);
    end
    vectors++;
    if (first_press != D + 3) begin
      miscompares++;
      $display("FAIL press_latency got=%0d exp=%0d", first_press, D + 3);
    end
    vectors++;
    if (rep_edges.size() < 2 || rep_edges[0] != D + 3 + H || rep_edges[1] != D + 3 + H + R) begin
      miscompares++;
      $display("FAIL repeat_timing got_n=%0d first=%0d exp=%0d/%0d", rep_edges.size(),
               (rep_edges.size() > 0) ? rep_edges[0] : -1, D + 3 + H, D + 3 + H + R);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clean_release edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
    end
  endtask

  task automatic test_press_bounce();
    logic [4:0] obs, exp;
    int activity;
    activity = 0;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      drive((i < 12) ? logic'((i / 2) % 2) : 1'b1);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL press_bounce edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (obs !== 5'b0) activity++;
    end
    vectors++;
    if (activity != 0) begin
      miscompares++;
      $display("FAIL press_bounce_quiet got=%0d active cycles exp=0", activity);
    end
  endtask

  task automatic test_release_bounce();
    logic [4:0] obs, exp;
    logic pat[$];
    int presses, releases, rel_edge;
    presses = 0; releases = 0; rel_edge = -1;
    apply_reset();
    for (int i = 0; i < 10; i++) pat.push_back(1'b0);
    for (int i = 0; i < 2; i++)  pat.push_back(1'b1);
    for (int i = 0; i < 3; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    foreach (pat[i]) begin
      drive(pat[i]);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL release_bounce edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (edge_n > 10 && press_pulse === 1'b1) presses++;
      if (release_pulse === 1'b1) begin
        releases++;
        rel_edge = edge_n;
      end
    end
    vectors++;
    if (presses != 0 || releases != 1 || rel_edge != 22) begin
      miscompares++;
      $display("FAIL release_bounce_count got presses=%0d releases=%0d at=%0d exp 0/1/22",
               presses, releases, rel_edge);
    end
  endtask

  task automatic test_repeat_boundary();
    logic [4:0] obs, exp;
    int term, reps, rel_edge;
    logic rep_at_term;
    term = D + 3 + H + 3 * R;
    reps = 0; rel_edge = -1; rep_at_term = 1'bx;
    apply_reset();
    for (int i = 1; i <= term + 10; i++) begin
      drive((i >= term - 2) ? 1'b1 : 1'b0);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL repeat_boundary edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (repeat_pulse === 1'b1) reps++;
      if (edge_n == term) rep_at_term = repeat_pulse;
      if (release_pulse === 1'b1) rel_edge = edge_n;
    end
    vectors++;
    if (reps != 3 || rep_at_term !== 1'b0 || rel_edge != term + D) begin
      miscompares++;
      $display("FAIL repeat_boundary_rule got reps=%0d rep_at_term=%b rel=%0d exp 3/0/%0d",
               reps, rep_at_term, rel_edge, term + D);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] obs, exp;
    int presses, press_edge;
    presses = 0; press_edge = -1;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mid_hold_pre edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("FAIL async_reset got=%b exp=00000", obs);
    end
    model_reset();
    @(negedge clk_50mhz);
    reset  = 1'b0;
    edge_n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mid_hold_post edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (press_pulse === 1'b1) begin
        presses++;
        press_edge = edge_n;
      end
    end
    vectors++;
    if (presses != 1 || press_edge != D + 3) begin
      miscompares++;
      $display("FAIL reset_repress got presses=%0d at=%0d exp 1 at %0d", presses, press_edge, D + 3);
    end
  endtask

  task automatic test_random();
    logic [4:0] obs, exp;
    logic lvl;
    int len;
    apply_reset();
    for (int run = 0; run < 60; run++) begin
      lvl = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 3 * D);
      for (int k = 0; k < len; k++) begin
        drive(lvl);
        obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
        exp = exp_q.pop_front();
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL random edge=%0d got=%b exp=%b", edge_n, obs, exp);
        end
      end
    end
  endtask

`ifdef BUTTON_COND_ACCEL_EN
  task automatic test_accel();
    logic [4:0] obs, exp;
    int rep_edges[$];
    int gap_bad;
    gap_bad = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0);
      obs = {pressed, press_pulse, repeat_pulse, release_pulse, step};
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL accel edge=%0d got=%b exp=%b", edge_n, obs, exp);
      end
      if (repeat_pulse === 1'b1) rep_edges.push_back(edge_n);
    end
    for (int i = 1; i < rep_edges.size(); i++) begin
      if (rep_edges[i] - rep_edges[i-1] != ((i <= 8) ? 16 : (i <= 16) ? 8 : (i <= 24) ? 4 : 2))
        gap_bad++;
    end
    vectors++;
    if (rep_edges.size() != 54 || gap_bad != 0) begin
      miscompares++;
      $display("FAIL accel_schedule got reps=%0d bad_gaps=%0d exp 54/0", rep_edges.size(), gap_bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_repeat_boundary();
    test_reset_mid_hold();
    test_random();
`ifdef BUTTON_COND_ACCEL_EN
    test_accel();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog edge=%0d exp=bench finished", edge_n);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
